bch_encoder_block: RTL
======================

BCH_ENCODER_BLOCK -- requirements
Module: bch_encoder_block

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- msg_in  in  7  message m[6:0], m[6] = coefficient of x^6.
- err_mask_in  in  15  error pattern XORed into the emitted codeword; captured with the message.
- in_valid  in  1  msg_in/err_mask_in valid.
- in_ready  out  1  block can accept a message.
- codeword_out  out  15  encoded codeword XOR captured mask; bit i = coefficient of x^i.
- clean_codeword_out  out  15  encoded codeword without the mask.
- out_valid  out  1  codeword outputs valid.
- out_ready  in  1  downstream consumer (decoder bench/top) accepts the codeword.
- busy  out  1  high in any state other than IDLE.

REQ-002 The block SHALL have one parameter: none; the code SHALL be fixed as BCH(15,7), t=2, g(x)=x^8+x^7+x^6+x^4+1 (8'hD1 low byte).

Function
REQ-003 The block SHALL be systematic: codeword[14:8]=m[6:0], codeword[7:0]=remainder of m(x)*x^8 mod g(x).
REQ-004 The FSM SHALL have states IDLE, SHIFT, HOLD.
REQ-005 IDLE: in_ready=1. On in_valid=1, latch msg_in and err_mask_in, clear parity register to 0, clear bit counter to 0, go to SHIFT.
REQ-006 SHIFT: in_ready=0. Process one message bit per cycle, MSB first (m[6] on count 0, m[0] on count 6): fb = bit ^ par[7]; par <= {par[6:0],1'b0} ^ (fb ? 8'hD1 : 8'h00).
REQ-007 SHIFT SHALL last exactly 7 cycles (counter 0..6). On count 6, register the outputs and go to HOLD.
REQ-008 HOLD: out_valid=1. codeword_out = {m,par} ^ mask; clean_codeword_out = {m,par}. Both SHALL be held stable while out_ready=0.
REQ-009 HOLD with out_ready=1: the transfer completes that edge and the FSM returns to IDLE. in_ready SHALL stay 0 during HOLD, so accept and emit never overlap.
REQ-010 Latency SHALL be 8 cycles from the accepting edge to the first cycle with out_valid=1. Throughput SHALL be at most one codeword per 9 cycles.
REQ-011 in_valid outside IDLE SHALL be ignored. msg_in/err_mask_in changes after acceptance SHALL NOT affect the result.
REQ-012 out_valid and in_ready SHALL never both be 1. busy SHALL be the inverse of in_ready.
REQ-013 Outputs SHALL be registered, with no combinational path from in_valid/out_ready to codeword outputs.

Reset
REQ-014 On rst=1, asynchronously: FSM=IDLE, in_ready=1 after release, out_valid=0, busy=0, codeword_out=0, clean_codeword_out=0, parity/counter/latched message/mask=0.
REQ-015 Reset mid-SHIFT or mid-HOLD SHALL abort the word with no output pulse. The first in_valid after release SHALL start a fresh encode.

Verification
REQ-016 msg_in=7'h01, mask=0, out_ready=1 -> after 8 cycles codeword_out=clean=15'h01D1, out_valid for 1 cycle.
REQ-017 msg_in=7'h00 -> codeword 15'h0000. msg_in=7'h7F -> codeword 15'h7FFF (parity 8'hFF).
REQ-018 msg_in=7'h01, err_mask_in=15'h4001 -> codeword_out=15'h41D0, clean_codeword_out=15'h01D1. When fed to the decoder top, the corrected output is 15'h01D1.
REQ-019 out_ready held 0 for 5 cycles in HOLD -> out_valid and data stable. in_valid pulses ignored. Transfer occurs on the first out_ready=1, then in_ready=1 the next cycle.
REQ-020 rst asserted at SHIFT count 3 -> out_valid never rises, outputs 0. A new msg 7'h01 encodes to 15'h01D1.
REQ-021 Random 7-bit messages, back-to-back in_valid -> every clean codeword is divisible by g(x) (decoder syndromes S1=S2=S3=0), and one output per accepted input in order.

Source files
------------

// File: rtl/bch_encoder_block.sv
// Systematic BCH(15,7) t=2 encoder with g(x) = x^8+x^7+x^6+x^4+1.
// Handshaked: accept a message in IDLE, shift 7 bits through the parity LFSR, then hold the codeword.
module bch_encoder_block (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  msg_in,
    input  logic [14:0] err_mask_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [14:0] codeword_out,
    output logic [14:0] clean_codeword_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam logic [7:0] GEN_LOW = 8'hD1;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t      r_state;
    logic [6:0]  r_msg;
    logic [6:0]  r_msg_sh;
    logic [14:0] r_mask;
    logic [7:0]  r_par;
    logic [2:0]  r_cnt;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_busy;
    logic [14:0] r_codeword;
    logic [14:0] r_clean;

    logic        w_fb;
    logic [7:0]  w_par_next;

    // r_msg_sh presents the current message bit at its MSB, m[6] first
    assign w_fb       = r_msg_sh[6] ^ r_par[7];
    assign w_par_next = {r_par[6:0], 1'b0} ^ (w_fb ? GEN_LOW : 8'h00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_msg       <= '0;
            r_msg_sh    <= '0;
            r_mask      <= '0;
            r_par       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_codeword  <= '0;
            r_clean     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_msg      <= msg_in;
                        r_msg_sh   <= msg_in;
                        r_mask     <= err_mask_in;
                        r_par      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_par    <= w_par_next;
                    r_msg_sh <= {r_msg_sh[5:0], 1'b0};
                    r_cnt    <= r_cnt + 3'd1;
                    if (r_cnt == 3'd6) begin
                        r_clean     <= {r_msg, w_par_next};
                        r_codeword  <= {r_msg, w_par_next} ^ r_mask;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    // Outputs stay frozen until the consumer takes the word
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready           = r_in_ready;
    assign out_valid          = r_out_valid;
    assign busy               = r_busy;
    assign codeword_out       = r_codeword;
    assign clean_codeword_out = r_clean;

endmodule
